// File: rtl/instr_fetch_unit_if.sv
// Bundle of program-load, run control and instruction handshake signals around the
// instruction fetch unit. master = the fetch unit, slave = the loader/control unit side.
interface instr_fetch_unit_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned IW = 8
);
  logic          load_en;
  logic [IW-1:0] load_data;
  logic          clear_prog;
  logic          run;
  logic          loop;
  logic          instr_req;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic [AW:0]   prog_len;
  logic          load_full;
  logic          halted;

  modport master (
    input  load_en, load_data, clear_prog, run, loop, instr_req,
    output instr, instr_valid, pc, prog_len, load_full, halted
  );

  modport slave (
    output load_en, load_data, clear_prog, run, loop, instr_req,
    input  instr, instr_valid, pc, prog_len, load_full, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program store plus fetch sequencer: bytes are loaded while idle, then presented
// in order over a valid/request handshake, optionally looping back to slot 0.
module instr_fetch_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned IW    = 8
) (
  input  logic              clock_pulse,
  input  logic              resetn,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRead    = 2'b01,
    StPresent = 2'b10,
    StHalt    = 2'b11
  } state_e;

  localparam logic [AW:0]   LenOne = (AW + 1)'(1);
  localparam logic [AW-1:0] PcOne  = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [IW-1:0] instr_q, instr_d;
  logic          valid_q, valid_d;
  logic          halted_q, halted_d;
  logic          mem_we;
  logic [AW:0]   pc_inc_ext;
  logic          load_full;

  logic [IW-1:0] mem [DEPTH];

  // prog_len never exceeds DEPTH, so its top bit alone means "full".
  assign load_full  = prog_len_q[AW];
  assign pc_inc_ext = {1'b0, pc_q} + LenOne;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prog_len_d = prog_len_q;
    instr_d    = instr_q;
    mem_we     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.clear_prog) begin
          prog_len_d = '0;
        end else if (bus.load_en) begin
          if (!load_full) begin
            mem_we     = 1'b1;
            prog_len_d = prog_len_q + LenOne;
          end
        end else if (bus.run && (prog_len_q != '0)) begin
          state_d = StRead;
        end
      end
      StRead: begin
        if (!bus.run) begin
          state_d = StIdle;
          pc_d    = '0;
        end else begin
          instr_d = mem[pc_q];
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (!bus.run) begin
          // Abort wins over a request in the same cycle.
          state_d = StIdle;
          pc_d    = '0;
        end else if (bus.instr_req) begin
          if (pc_inc_ext < prog_len_q) begin
            pc_d    = pc_q + PcOne;
            state_d = StRead;
          end else if (bus.loop) begin
            pc_d    = '0;
            state_d = StRead;
          end else begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (!bus.run) begin
          state_d = StIdle;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = StIdle;
        pc_d    = '0;
      end
    endcase

    valid_d  = (state_d == StPresent);
    halted_d = (state_d == StHalt);
  end

  always_ff @(posedge clock_pulse) begin
    if (!resetn) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      prog_len_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      prog_len_q <= prog_len_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

  // Program storage is deliberately left out of reset.
  always_ff @(posedge clock_pulse) begin
    if (mem_we) begin
      mem[prog_len_q[AW-1:0]] <= bus.load_data;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.prog_len    = prog_len_q;
  assign bus.load_full   = load_full;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change and outputs are sampled on the
// falling edge, so every check sees the state left by the preceding rising edge.
module tb_instr_fetch_unit;

  logic clock_pulse;
  logic resetn;
  int   n_total;
  int   n_bad;

  instr_fetch_unit_if #(.AW(4), .IW(8)) bus ();

  instr_fetch_unit #(
    .DEPTH(16),
    .AW   (4),
    .IW   (8)
  ) dut (
    .clock_pulse(clock_pulse),
    .resetn     (resetn),
    .bus        (bus)
  );

  initial clock_pulse = 1'b0;
  always #5 clock_pulse = ~clock_pulse;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock_pulse);
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.load_en   = 1'b1;
    bus.load_data = b;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".instr"}, 32'(bus.instr), 32'h0);
    check_eq({tag, ".valid"}, 32'(bus.instr_valid), 32'h0);
    check_eq({tag, ".pc"}, 32'(bus.pc), 32'h0);
    check_eq({tag, ".prog_len"}, 32'(bus.prog_len), 32'h0);
    check_eq({tag, ".load_full"}, 32'(bus.load_full), 32'h0);
    check_eq({tag, ".halted"}, 32'(bus.halted), 32'h0);
  endtask

  logic [7:0] prog1 [3];

  initial begin
    n_total = 0;
    n_bad   = 0;
    prog1[0] = 8'h9D;
    prog1[1] = 8'hB4;
    prog1[2] = 8'h90;

    resetn         = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_data  = 8'h00;
    bus.clear_prog = 1'b0;
    bus.run        = 1'b0;
    bus.loop       = 1'b0;
    bus.instr_req  = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    resetn = 1'b1;

    // Three-instruction program, no loop, consumer always ready.
    for (int i = 0; i < 3; i++) load_byte(prog1[i]);
    check_eq("t1.prog_len", 32'(bus.prog_len), 32'd3);
    bus.loop      = 1'b0;
    bus.instr_req = 1'b1;
    bus.run       = 1'b1;
    tick();
    check_eq("t1.start_gap", 32'(bus.instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t1.valid", 32'(bus.instr_valid), 32'h1);
      check_eq("t1.instr", 32'(bus.instr), 32'(prog1[i]));
      check_eq("t1.pc", 32'(bus.pc), 32'(i));
      tick();
      check_eq("t1.gap_valid", 32'(bus.instr_valid), 32'h0);
    end
    check_eq("t1.halted", 32'(bus.halted), 32'h1);
    check_eq("t1.halt_pc", 32'(bus.pc), 32'd2);
    tick();
    check_eq("t1.halt_hold", 32'(bus.halted), 32'h1);
    bus.run = 1'b0;
    tick();
    check_eq("t1.idle_halted", 32'(bus.halted), 32'h0);
    check_eq("t1.idle_pc", 32'(bus.pc), 32'h0);

    // Start latency and stall with instr_req low.
    bus.clear_prog = 1'b1;
    tick();
    bus.clear_prog = 1'b0;
    load_byte(8'h5A);
    check_eq("t2.prog_len", 32'(bus.prog_len), 32'd1);
    bus.instr_req = 1'b0;
    bus.run       = 1'b1;
    tick();
    check_eq("t2.latency_gap", 32'(bus.instr_valid), 32'h0);
    tick();
    check_eq("t2.first_valid", 32'(bus.instr_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2.stall_valid", 32'(bus.instr_valid), 32'h1);
      check_eq("t2.stall_instr", 32'(bus.instr), 32'h5A);
      check_eq("t2.stall_pc", 32'(bus.pc), 32'h0);
    end
    bus.run = 1'b0;
    tick();
    check_eq("t2.abort_valid", 32'(bus.instr_valid), 32'h0);

    // Fill all slots, overflow load ignored, then loop.
    bus.clear_prog = 1'b1;
    tick();
    bus.clear_prog = 1'b0;
    for (int i = 0; i < 16; i++) load_byte(8'(i));
    check_eq("t3.full", 32'(bus.load_full), 32'h1);
    check_eq("t3.prog_len", 32'(bus.prog_len), 32'd16);
    load_byte(8'hFF);
    check_eq("t3.ovf_len", 32'(bus.prog_len), 32'd16);
    bus.loop      = 1'b1;
    bus.instr_req = 1'b1;
    bus.run       = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      tick();
      check_eq("t3.loop_instr", 32'(bus.instr), 32'(i % 16));
      check_eq("t3.loop_pc", 32'(bus.pc), 32'(i % 16));
      check_eq("t3.loop_valid", 32'(bus.instr_valid), 32'h1);
      tick();
      check_eq("t3.loop_halted", 32'(bus.halted), 32'h0);
    end
    bus.run = 1'b0;
    tick();

    // Abort at pc=2 with a simultaneous request.
    bus.loop = 1'b0;
    bus.run  = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i < 2) tick();
    end
    check_eq("t4.pre_pc", 32'(bus.pc), 32'd2);
    check_eq("t4.pre_valid", 32'(bus.instr_valid), 32'h1);
    check_eq("t4.pre_instr", 32'(bus.instr), 32'h02);
    bus.run = 1'b0;
    tick();
    check_eq("t4.abort_valid", 32'(bus.instr_valid), 32'h0);
    check_eq("t4.abort_pc", 32'(bus.pc), 32'h0);
    bus.run = 1'b1;
    tick();
    tick();
    check_eq("t4.rerun_instr", 32'(bus.instr), 32'h00);
    check_eq("t4.rerun_pc", 32'(bus.pc), 32'h0);
    bus.run = 1'b0;
    tick();

    // clear_prog beats load_en; load_en blocks the run transition.
    bus.instr_req  = 1'b0;
    bus.clear_prog = 1'b1;
    tick();
    bus.clear_prog = 1'b0;
    load_byte(8'hA1);
    load_byte(8'hA2);
    check_eq("t5.len2", 32'(bus.prog_len), 32'd2);
    bus.clear_prog = 1'b1;
    bus.load_en    = 1'b1;
    bus.load_data  = 8'h77;
    tick();
    bus.clear_prog = 1'b0;
    check_eq("t5.clear_prio", 32'(bus.prog_len), 32'd0);
    bus.load_data = 8'hC3;
    bus.run       = 1'b1;
    tick();
    bus.load_en = 1'b0;
    check_eq("t5.load_run_len", 32'(bus.prog_len), 32'd1);
    tick();
    check_eq("t5.still_idle", 32'(bus.instr_valid), 32'h0);
    tick();
    check_eq("t5.late_valid", 32'(bus.instr_valid), 32'h1);
    check_eq("t5.late_instr", 32'(bus.instr), 32'hC3);
    bus.run = 1'b0;
    tick();

    // Reset while presenting pc=5, then run with an empty program.
    for (int i = 1; i < 6; i++) load_byte(8'(8'h11 * i));
    check_eq("t6.len6", 32'(bus.prog_len), 32'd6);
    bus.instr_req = 1'b1;
    bus.run       = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 5) tick();
    end
    check_eq("t6.pre_pc", 32'(bus.pc), 32'd5);
    check_eq("t6.pre_instr", 32'(bus.instr), 32'h55);
    check_eq("t6.pre_valid", 32'(bus.instr_valid), 32'h1);
    resetn = 1'b0;
    tick();
    check_reset_state("t6.reset");
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t6.empty_valid", 32'(bus.instr_valid), 32'h0);
      check_eq("t6.empty_pc", 32'(bus.pc), 32'h0);
    end
    bus.run = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
